// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX write-port arbiter.
package uart_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept
    always_comb begin
        found  = 1'b0;
        idx    = {W{1'b0}};
        cand_s = {(W + 1){1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr} + (W + 1)'(i);
            cand_s = (cand_s >= (W + 1)'(N)) ? (cand_s - (W + 1)'(N)) : cand_s;
            found  = found | req[cand_s[W-1:0]];
            idx    = req[cand_s[W-1:0]] ? cand_s[W-1:0] : idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin lock arbiter in front of the TX fifo write port.
// Optional per-requester byte counters on o_bytes when UART_TX_ARB_STATS_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DLEN     = 8,
    parameter int MAXBURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ-1:0]          i_last,
    input  logic [NREQ*DLEN-1:0]     i_data,
    output logic [NREQ-1:0]          o_gnt,
    output logic                     o_wen,
    output logic [DLEN-1:0]          o_wdata,
    input  logic                     i_full,
    output logic                     o_busy,
    output logic [$clog2(NREQ)-1:0]  o_owner
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]    o_bytes
`endif
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST + 1);

    arb_state_e      state_r;
    logic [OW-1:0]   owner_r;
    logic [OW-1:0]   rr_ptr_r;
    logic [BW-1:0]   beat_r;
    logic            busy_r;

    logic            pick_found_s;
    logic [OW-1:0]   pick_idx_s;
    logic            lock_s;
    logic            owner_req_s;
    logic            owner_last_s;
    logic            xfer_s;
    logic [BW-1:0]   beat_next_s;
    logic            burst_done_s;
    logic            abandon_s;
    logic            release_s;
    logic [OW-1:0]   next_ptr_s;
    logic [NREQ-1:0] gnt_s;

    rr_pick #(
        .N (NREQ),
        .W (OW)
    ) u_pick (
        .req   (i_req),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign lock_s       = (state_r == ST_LOCK);
    assign owner_req_s  = i_req[owner_r];
    assign owner_last_s = i_last[owner_r];
    assign xfer_s       = lock_s & ~i_full & owner_req_s;
    assign beat_next_s  = beat_r + BW'(1'b1);
    assign burst_done_s = (beat_next_s == BW'(MAXBURST));
    // A dropped request only counts as abandon when the buffer could have accepted it
    assign abandon_s    = lock_s & ~owner_req_s & ~i_full;
    assign release_s    = (xfer_s & (owner_last_s | burst_done_s)) | abandon_s;
    assign next_ptr_s   = (owner_r == OW'(NREQ - 1)) ? {OW{1'b0}} : (owner_r + OW'(1'b1));

    // Ready is gated by i_full directly so a write can never land on a full buffer
    always_comb begin
        gnt_s          = {NREQ{1'b0}};
        gnt_s[owner_r] = lock_s & ~i_full;
    end

    assign o_gnt   = gnt_s;
    assign o_wen   = xfer_s;
    assign o_wdata = i_data[int'(owner_r)*DLEN +: DLEN];
    assign o_busy  = busy_r;
    assign o_owner = owner_r;

    // Arbitration FSM: lock owner, round-robin pointer and beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            owner_r  <= {OW{1'b0}};
            rr_ptr_r <= {OW{1'b0}};
            beat_r   <= {BW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r <= ST_LOCK;
                        owner_r <= pick_idx_s;
                        beat_r  <= {BW{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOCK: begin
                    if (release_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_ptr_s;
                        busy_r   <= 1'b0;
                    end else if (xfer_s) begin
                        beat_r <= beat_next_s;
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_ARB_STATS_EN
    for (genvar k = 0; k < NREQ; k++) begin : g_stats
        logic [CNT_W-1:0] cnt_r;

        // Per-requester transferred-byte count, wrapping naturally
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (xfer_s && (owner_r == OW'(k))) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end

        assign o_bytes[k*CNT_W +: CNT_W] = cnt_r;
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (MAXBURST 16 and 4) share stimulus.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i_req = 4'h0;
    logic [3:0]  i_last = 4'h0;
    logic [31:0] i_data = 32'h0;
    logic        i_full = 1'b0;

    logic [3:0]  gnt16, gnt4;
    logic        wen16, wen4, busy16, busy4;
    logic [7:0]  wdata16, wdata4;
    logic [1:0]  owner16, owner4;
`ifdef UART_TX_ARB_STATS_EN
    logic [63:0] bytes16, bytes4;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4), .DLEN(8), .MAXBURST(16)) dut16 (
        .clk(clk), .rst(rst), .i_req(i_req), .i_last(i_last), .i_data(i_data),
        .o_gnt(gnt16), .o_wen(wen16), .o_wdata(wdata16), .i_full(i_full),
        .o_busy(busy16), .o_owner(owner16)
`ifdef UART_TX_ARB_STATS_EN
        , .o_bytes(bytes16)
`endif
    );

    uart_tx_arbiter #(.NREQ(4), .DLEN(8), .MAXBURST(4)) dut4 (
        .clk(clk), .rst(rst), .i_req(i_req), .i_last(i_last), .i_data(i_data),
        .o_gnt(gnt4), .o_wen(wen4), .o_wdata(wdata4), .i_full(i_full),
        .o_busy(busy4), .o_owner(owner4)
`ifdef UART_TX_ARB_STATS_EN
        , .o_bytes(bytes4)
`endif
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        sel = 1'b0;
    logic        mon_en = 1'b1;
    logic [3:0]  hs = 4'h0;
    logic [3:0]  req_mask = 4'hF;

    logic [7:0]  src_d [4][16];
    logic        src_l [4][16];
    int          src_len [4];
    int          src_pos [4];

    logic [7:0]  wq_d [$];
    logic [1:0]  wq_o [$];
    int          wq_c [$];
    logic [7:0]  exp_q [$];

    logic [3:0]  mon_gnt;
    logic        mon_wen;
    logic [7:0]  mon_wdata;
    logic [1:0]  mon_owner;

    assign mon_gnt   = sel ? gnt4 : gnt16;
    assign mon_wen   = sel ? wen4 : wen16;
    assign mon_wdata = sel ? wdata4 : wdata16;
    assign mon_owner = sel ? owner4 : owner16;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer-side log of every write of the selected instance
    always @(negedge clk) begin
        if (mon_en && mon_wen) begin
            wq_d.push_back(mon_wdata);
            wq_o.push_back(mon_owner);
            wq_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr_src();
        for (int k = 0; k < 4; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        req_mask = 4'hF;
        exp_q.delete();
    endtask

    task automatic add(input int k, input logic [7:0] d, input logic l);
        src_d[k][src_len[k]] = d;
        src_l[k][src_len[k]] = l;
        src_len[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (src_pos[k] < src_len[k] && req_mask[k]) begin
                i_req[k]          = 1'b1;
                i_last[k]         = src_l[k][src_pos[k]];
                i_data[k*8 +: 8]  = src_d[k][src_pos[k]];
            end else begin
                i_req[k]          = 1'b0;
                i_last[k]         = 1'b0;
                i_data[k*8 +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        hs = mon_gnt & i_req;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) src_pos[k]++;
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            at_neg();
            to_pos();
        end
    endtask

    task automatic do_reset(input logic check);
        rst = 1'b1;
        drive();
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (check) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt16), 32'h0);
            chk("rst_wen", 32'(wen16), 32'h0);
            chk("rst_busy", 32'(busy16), 32'h0);
            chk("rst_owner", 32'(owner16), 32'h0);
            chk("rst_wdata", 32'(wdata16), 32'h10);
            chk("rst_busy4", 32'(busy4), 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        hs = 4'h0;
        wq_d.delete();
        wq_o.delete();
        wq_c.delete();
    endtask

    task automatic check_data(input string tag);
        logic [31:0] obs;
        chk({tag, "_count"}, 32'(wq_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < wq_d.size()) ? 32'(wq_d[i]) : 32'hDEAD;
            chk($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
        end
    endtask

    function automatic logic [31:0] own_at(input int i);
        return (i < wq_o.size()) ? 32'(wq_o[i]) : 32'hDEAD;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < wq_c.size()) ? wq_c[i] : -1000;
    endfunction

`ifdef UART_TX_ARB_STATS_EN
    int stat_cnt;
`endif

    initial begin
        // Reset with everyone requesting, then 1-byte round robin
        clr_src();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                add(k, 8'(((k + 1) << 4) | r), 1'b1);
        do_reset(1'b1);
        run(20);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(8'(((k + 1) << 4) | r));
        check_data("rr");
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_owner%0d", i), own_at(i), 32'(i % 4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_gap%0d", i), 32'(cyc_at(i + 1) - cyc_at(i)), 32'd2);
        at_neg();
        chk("idle_wen", 32'(wen16), 32'h0);
        chk("idle_busy", 32'(busy16), 32'h0);
        to_pos();

        // Owner's message stays contiguous while another requester waits
        clr_src();
        for (int i = 0; i < 5; i++) add(1, 8'hA0 + 8'(i), (i == 4));
        add(2, 8'hB0, 1'b0);
        add(2, 8'hB1, 1'b1);
        do_reset(1'b0);
        run(14);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        check_data("nointl");
        chk("nointl_span", 32'(cyc_at(4) - cyc_at(0)), 32'd4);

        // Forced release after MAXBURST=4 beats
        sel = 1'b1;
        clr_src();
        for (int i = 0; i < 10; i++) add(0, 8'(i), 1'b0);
        add(3, 8'hC0, 1'b0);
        add(3, 8'hC1, 1'b1);
        do_reset(1'b0);
        run(24);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        for (int i = 4; i < 10; i++) exp_q.push_back(8'(i));
        check_data("maxb");
        chk("maxb_own3", own_at(3), 32'd0);
        chk("maxb_own4", own_at(4), 32'd3);
        chk("maxb_own6", own_at(6), 32'd0);
        sel = 1'b0;

        // Backpressure mid-burst, owner briefly drops request while full
        clr_src();
        for (int i = 0; i < 6; i++) add(0, 8'hD0 + 8'(i), (i == 5));
        do_reset(1'b0);
        run(3);
        for (int i = 0; i < 3; i++) begin
            i_full = 1'b1;
            req_mask = (i == 1) ? 4'b1110 : 4'b1111;
            drive();
            at_neg();
            chk($sformatf("bp_gnt%0d", i), 32'(gnt16), 32'h0);
            chk($sformatf("bp_wen%0d", i), 32'(wen16), 32'h0);
            chk($sformatf("bp_busy%0d", i), 32'(busy16), 32'h1);
            to_pos();
        end
        i_full = 1'b0;
        req_mask = 4'hF;
        drive();
        run(8);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'hD0 + 8'(i));
        check_data("bp");
        chk("bp_gap", 32'(cyc_at(2) - cyc_at(1)), 32'd4);

        // Abandon: owner drops request with buffer not full
        clr_src();
        for (int i = 0; i < 3; i++) add(0, 8'hE0 + 8'(i), 1'b0);
        add(1, 8'hF0, 1'b1);
        do_reset(1'b0);
        run(10);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'hE0 + 8'(i));
        exp_q.push_back(8'hF0);
        check_data("abn");
        chk("abn_gap", 32'(cyc_at(3) - cyc_at(2)), 32'd3);
        chk("abn_own", own_at(3), 32'd1);

`ifdef UART_TX_ARB_STATS_EN
        // Counter wrap: 65537 bytes from requester 2
        clr_src();
        do_reset(1'b0);
        mon_en = 1'b0;
        i_req = 4'b0100;
        i_last = 4'b0000;
        i_data = 32'h0055_0000;
        stat_cnt = 0;
        for (int c = 0; c < 75000 && stat_cnt < 65537; c++) begin
            @(negedge clk);
            if (wen16) stat_cnt++;
            @(posedge clk); #1;
        end
        i_req = 4'b0000;
        chk("stats_reached", 32'(stat_cnt), 32'd65537);
        @(posedge clk); #1;
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            chk($sformatf("stats_bytes%0d", k), 32'(bytes16[k*16 +: 16]), (k == 2) ? 32'd1 : 32'd0);
        chk("stats4_bytes0", 32'(bytes4[15:0]), 32'd0);
        chk("stats4_bytes1", 32'(bytes4[31:16]), 32'd0);
        chk("stats4_bytes3", 32'(bytes4[63:48]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the TX buffer write port (2..16).
REQ-002 SHALL have parameter DLEN, default 8: data width per byte.
REQ-003 SHALL have parameter MAXBURST, default 16: maximum bytes per grant before forced release (1..256).
REQ-004 SHALL have port clk  input  1: single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port i_req  input  NREQ: per-requester byte valid.
REQ-007 SHALL have port i_last  input  NREQ: per-requester marker for the final byte of a message.
REQ-008 SHALL have port i_data  input  NREQ x DLEN: per-requester byte, packed with requester k at bits [k*DLEN +: DLEN].
REQ-009 SHALL have port o_gnt  output  NREQ: per-requester ready; a byte transfers when i_req[k] & o_gnt[k].
REQ-010 SHALL have port o_wen  output  1: TX buffer write enable.
REQ-011 SHALL have port o_wdata  output  DLEN: TX buffer write data.
REQ-012 SHALL have port i_full  input  1: TX buffer full.
REQ-013 SHALL have port o_busy  output  1: a requester holds the lock.
REQ-014 SHALL have port o_owner  output  $clog2(NREQ): index of the lock holder, valid when o_busy=1.

Function
REQ-015 SHALL implement the states IDLE and LOCK.
- IDLE: select the first k with i_req[k]=1, searching from rr_ptr upward with wrap.
- Store k as owner and go to LOCK on the next edge.
- IDLE is a 1-cycle arbitration bubble.
- o_gnt=0 in IDLE.
REQ-016 SHALL drive o_gnt[k] = (state==LOCK) & (owner==k) & ~i_full, combinationally; every other bit is 0.
REQ-017 SHALL drive o_wen = i_req[owner] & o_gnt[owner] and o_wdata = the owner's i_data slice, combinationally (zero latency), so a write never reaches a full buffer.
REQ-018 SHALL keep a beat counter, reset to 0 on entry to LOCK and incremented on each transfer.
REQ-019 SHALL release the lock (go to IDLE, rr_ptr = (owner+1) mod NREQ) on the first of:
- a transfer with i_last[owner]=1;
- a transfer that makes the beat count equal MAXBURST;
- a cycle in LOCK where i_req[owner]=0 and i_full=0 (abandon).
REQ-020 SHALL hold the lock with no transfer while i_full=1; an owner dropping i_req during i_full is not treated as abandon.
REQ-021 SHALL ignore i_req and i_last of non-owners; their bytes are never written.
REQ-022 SHALL stay in IDLE with o_wen=0 when i_req=0.
REQ-023 SHALL guarantee that no requester waits more than NREQ-1 bursts while holding i_req.

Reset
REQ-024 SHALL, when rst=1 at an edge, set:
- state IDLE, rr_ptr 0, owner 0, beat counter 0;
- o_gnt 0, o_wen 0, o_busy 0, o_owner 0;
- o_wdata equal to the requester-0 slice of i_data.
REQ-025 SHALL, on rst mid-burst, abandon the burst without an end marker; the lost bytes are the requester's responsibility.

Configuration
REQ-026 SHALL, with UART_TX_ARB_STATS_EN defined, add output o_bytes (NREQ x 16).
- Per-requester count of transferred bytes, wrapping at 65535 -> 0.
- Cleared by rst.
REQ-027 SHALL, with UART_TX_ARB_STATS_EN undefined, omit o_bytes and all counter logic.

Structure
REQ-028 SHALL place the state enum and the counter width constant (16) in package uart_pkg.
REQ-029 SHALL use one sub-module, rr_pick: a combinational rotate-priority selector (inputs req vector and pointer; outputs found flag and index).
REQ-030 SHALL be instantiated between uart_controller-style requesters and the TX fifo write port (i_wen, i_wdata, o_wfull).

Verification
REQ-031 Reset: assert rst with i_req=4'b1111 -> o_gnt=0, o_wen=0, o_busy=0; first grant after release of rst goes to requester 0.
REQ-032 Round robin: all four requesters send 1-byte messages (i_last=1) continuously -> grant order 0,1,2,3,0; each write is 1 byte followed by a 1-cycle bubble.
REQ-033 No interleave: req1 sends 5 bytes 0xA0..0xA4 (last on 0xA4) while req2 sends -> buffer receives 0xA0..0xA4 contiguously, then req2's bytes.
REQ-034 MAXBURST=4: req0 streams 10 bytes without i_last while req3 waits -> req0 is released after 4 bytes, req3 is granted, then req0 resumes.
REQ-035 Backpressure: i_full=1 for 3 cycles mid-burst -> o_gnt=0 and o_wen=0 in those cycles, lock held, no byte lost or duplicated; owner dropping i_req at i_full=0 -> release, and the next requester is granted 2 cycles later.
REQ-036 UART_TX_ARB_STATS_EN: 65537 single-byte transfers from req2 -> o_bytes[2]=1, all other counters 0.
